system_cpu_mult_unit: RTL and testbench

Parametrised iterative integer multiplier for the CPU's A-stage multiply path. It splits DATA_W-bit operands into SLICE_W-bit slices and accumulates one slice partial product per cycle through a single SLICE_W×SLICE_W unsigned multiplier. It supports the low-word product and signed, signed×unsigned and unsigned high-word products. Operands and results pass through valid/ready handshakes, so the pipeline can stall on either side.

---
 rtl/system_cpu_mult_pkg.sv | 23 ++
 rtl/system_cpu_mult_slice.sv | 12 +
 rtl/system_cpu_mult_unit.sv | 149 ++++++++++++++
 tb/tb_system_cpu_mult_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/system_cpu_mult_pkg.sv
// Shared definitions for the CPU multiply unit: op encoding, FSM state encoding and slice-count helper.
// The optional high-word path is controlled by the MULT_UNIT_HIGH_EN macro in system_cpu_mult_unit.
package system_cpu_mult_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } mult_op_t;

  typedef logic [1:0] mult_state_t;

  localparam mult_state_t ST_IDLE = 2'd0;
  localparam mult_state_t ST_MUL  = 2'd1;
  localparam mult_state_t ST_FIX  = 2'd2;
  localparam mult_state_t ST_DONE = 2'd3;

  function automatic int calc_k(input int data_w, input int slice_w);
    return data_w / slice_w;
  endfunction

endpackage

// File: rtl/system_cpu_mult_slice.sv
// Combinational unsigned SLICE_W x SLICE_W multiplier; kept separate so it maps onto a hard multiplier block.
module system_cpu_mult_slice #(
  parameter int SLICE_W = 16
) (
  input  logic [SLICE_W-1:0]   i_a,
  input  logic [SLICE_W-1:0]   i_b,
  output logic [2*SLICE_W-1:0] o_p
);

  assign o_p = {{SLICE_W{1'b0}}, i_a} * {{SLICE_W{1'b0}}, i_b};

endmodule

// File: rtl/system_cpu_mult_unit.sv
// Iterative slice-based integer multiplier for the A-stage. Define MULT_UNIT_HIGH_EN to enable
// MULH/MULHSU/MULHU (full 2*DATA_W accumulation plus sign fix-up); otherwise only the low word is built.
module system_cpu_mult_unit
  import system_cpu_mult_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [1:0]        dbg_state
);

  localparam int K     = calc_k(DATA_W, SLICE_W);
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

`ifdef MULT_UNIT_HIGH_EN
  localparam int ACC_W = 2 * DATA_W;
  localparam mult_state_t ST_AFTER_MUL = ST_FIX;
`else
  localparam int ACC_W = DATA_W;
  localparam mult_state_t ST_AFTER_MUL = ST_DONE;
`endif

  if ((SLICE_W < 1) || (SLICE_W > DATA_W) || ((DATA_W % SLICE_W) != 0)) begin : g_bad_param
    $error("system_cpu_mult_unit: DATA_W must be a non-zero multiple of SLICE_W");
  end

  mult_state_t        r_state;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [IDX_W-1:0]   r_i;
  logic [IDX_W-1:0]   r_j;
  logic [ACC_W-1:0]   r_acc;

  logic [SLICE_W-1:0]   w_a_slice;
  logic [SLICE_W-1:0]   w_b_slice;
  logic [2*SLICE_W-1:0] w_prod;
  logic [IDX_W:0]       w_ij;
  logic [ACC_W-1:0]     w_pp;
  logic                 w_last_pair;
  logic                 w_row_end;

  assign w_a_slice = r_a[int'(r_i)*SLICE_W +: SLICE_W];
  assign w_b_slice = r_b[int'(r_j)*SLICE_W +: SLICE_W];
  assign w_ij      = {1'b0, r_i} + {1'b0, r_j};
  assign w_pp      = ACC_W'(w_prod) << (SLICE_W * int'(w_ij));

  system_cpu_mult_slice #(.SLICE_W(SLICE_W)) u_slice (
    .i_a (w_a_slice),
    .i_b (w_b_slice),
    .o_p (w_prod)
  );

`ifdef MULT_UNIT_HIGH_EN
  mult_op_t r_op;
  logic     r_neg;
  logic     w_sign1;
  logic     w_sign2;

  // Row-major walk over the full K x K grid of slice pairs.
  assign w_row_end   = (r_j == LAST_IDX);
  assign w_last_pair = (r_i == LAST_IDX) && (r_j == LAST_IDX);
  // MUL shares MULH's sign handling: the low word is identical either way.
  assign w_sign1 = in_src1[DATA_W-1] & (in_op != OP_MULHU);
  assign w_sign2 = in_src2[DATA_W-1] & ((in_op == OP_MUL) || (in_op == OP_MULH));
  assign out_result = (r_op == OP_MUL) ? r_acc[DATA_W-1:0] : r_acc[2*DATA_W-1:DATA_W];
`else
  logic w_unused_op;

  // Only pairs with i+j < K can touch the low word; each row ends on the anti-diagonal.
  assign w_row_end   = (w_ij == (IDX_W + 1)'(K - 1));
  assign w_last_pair = (r_i == LAST_IDX);
  assign w_unused_op = ^in_op;
  assign out_result  = r_acc;
`endif

  // Handshakes: a transfer happens on any rising edge where valid and ready are both high;
  // in_ready depends only on state and out_valid/out_result hold steady until out_ready.
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_acc   <= '0;
`ifdef MULT_UNIT_HIGH_EN
      r_op    <= OP_MUL;
      r_neg   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_acc   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_state <= ST_MUL;
`ifdef MULT_UNIT_HIGH_EN
            r_op  <= mult_op_t'(in_op);
            r_neg <= w_sign1 ^ w_sign2;
            r_a   <= w_sign1 ? -in_src1 : in_src1;
            r_b   <= w_sign2 ? -in_src2 : in_src2;
`else
            r_a <= in_src1;
            r_b <= in_src2;
`endif
          end
        end
        ST_MUL: begin
          r_acc <= r_acc + w_pp;
          if (w_last_pair) begin
            r_state <= ST_AFTER_MUL;
          end else if (w_row_end) begin
            r_i <= r_i + IDX_W'(1);
            r_j <= '0;
          end else begin
            r_j <= r_j + IDX_W'(1);
          end
        end
        ST_FIX: begin
`ifdef MULT_UNIT_HIGH_EN
          if (r_neg) r_acc <= -r_acc;
`endif
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_system_cpu_mult_unit.sv
// Scoreboard bench for system_cpu_mult_unit; expectations adapt to whether MULT_UNIT_HIGH_EN is defined.
`timescale 1ns/1ps
module tb_system_cpu_mult_unit;
  import system_cpu_mult_pkg::*;

  localparam int DATA_W  = 32;
  localparam int SLICE_W = 16;
  localparam int K       = DATA_W / SLICE_W;
`ifdef MULT_UNIT_HIGH_EN
  localparam int LAT     = K * K + 2;
  localparam int SPACING = K * K + 3;
`else
  localparam int LAT     = K * (K + 1) / 2 + 1;
  localparam int SPACING = K * (K + 1) / 2 + 2;
`endif

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b1;
  logic [1:0]        in_op = 2'd0;
  logic [DATA_W-1:0] in_src1 = '0;
  logic [DATA_W-1:0] in_src2 = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_result;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DATA_W-1:0] exp_q[$];
  int                acc_q[$];
  int                prev_accept = -1;
  bit                chk_spacing = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  system_cpu_mult_unit #(.DATA_W(DATA_W), .SLICE_W(SLICE_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [DATA_W-1:0] ref_model(input logic [1:0] op, input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] ea;
    logic [2*DATA_W-1:0] eb;
    logic [2*DATA_W-1:0] p;
`ifdef MULT_UNIT_HIGH_EN
    ea = (op == OP_MULHU) ? {{DATA_W{1'b0}}, a} : {{DATA_W{a[DATA_W-1]}}, a};
    eb = (op == OP_MULH || op == OP_MUL) ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
    p  = ea * eb;
    return (op == OP_MUL) ? p[DATA_W-1:0] : p[2*DATA_W-1:DATA_W];
`else
    ea = {{DATA_W{1'b0}}, a};
    eb = {{DATA_W{1'b0}}, b};
    p  = ea * eb;
    return p[DATA_W-1:0];
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [DATA_W-1:0] exp);
    int budget = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high (cycle %0d)", cyc);
      in_valid = 1'b0;
      return;
    end
    if (chk_spacing && prev_accept >= 0) check("issue_spacing", DATA_W'(cyc - prev_accept), DATA_W'(SPACING));
    prev_accept = cyc;
    exp_q.push_back(exp);
    acc_q.push_back(cyc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = 2'($urandom);
    in_src1  = $urandom;
    in_src2  = $urandom;
  endtask

  task automatic wait_drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0_pending", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    bit prev_v = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        prev_v = 1'b0;
        continue;
      end
      if (out_valid && !prev_v) begin
        if (acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          check("latency", DATA_W'(cyc - acc_q.pop_front()), DATA_W'(LAT));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%h required=none", out_result);
        end else begin
          check("result", out_result, exp_q.pop_front());
        end
      end
      prev_v = out_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DATA_W-1:0] corners[5];
    logic [DATA_W-1:0] ra;
    logic [DATA_W-1:0] rb;
    logic [DATA_W-1:0] bp_exp;
    logic [1:0]        rop;
    int                budget;
    corners = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_in_ready", DATA_W'(in_ready), 1);
    check("reset_out_valid", DATA_W'(out_valid), 0);
    check("reset_out_result", out_result, 0);
    reset = 1'b0;

    // Directed products with hand-computed results.
`ifdef MULT_UNIT_HIGH_EN
    issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    issue(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    issue(OP_MULH,   32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF);
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
    issue(OP_MULHU,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
    bp_exp = 32'h0000_0001;
`else
    issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    issue(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    issue(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
    issue(OP_MULH,   32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD);
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE);
    issue(OP_MULHU,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE);
    bp_exp = 32'hFFFF_FFFE;
`endif
    wait_drain();

    // Backpressure: three stalled DONE cycles, accept on the fourth.
    out_ready = 1'b0;
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'h0000_0002, bp_exp);
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!out_valid && budget < 50);
    for (int s = 0; s < 3; s++) begin
      if (s > 0) @(negedge clk);
      #1;
      check("bp_out_valid", DATA_W'(out_valid), 1);
      check("bp_out_result", out_result, bp_exp);
      check("bp_in_ready", DATA_W'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_in_ready_after", DATA_W'(in_ready), 1);
    wait_drain();

    // Reset during the second MUL cycle discards the operation.
    issue(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, ref_model(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    @(negedge clk);
    #1;
    check("midreset_in_ready", DATA_W'(in_ready), 1);
    check("midreset_out_valid", DATA_W'(out_valid), 0);
    check("midreset_out_result", out_result, 0);
    reset = 1'b0;
    issue(OP_MUL, 32'd7, 32'd6, 32'd42);
    wait_drain();

    // Back-to-back random operations across all modes.
    prev_accept = -1;
    chk_spacing = 1'b1;
    for (int n = 0; n < 100; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      issue(rop, ra, rb, ref_model(rop, ra, rb));
    end
    chk_spacing = 1'b0;
    wait_drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
